timer_digit_loader: RTL and testbench
=====================================

TIMER_DIGIT_LOADER -- requirements
Module: timer_digit_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a key code must be held stable before it is accepted (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 D  input  4  BCD key code from the keypad priority encoder (0..9).
REQ-005 valid  input  1  high while any key is pressed; qualifies D.
REQ-006 enablen  input  1  active-low enable; high = keypad ignored.
REQ-007 clear  input  1  synchronous clear of the entered time.
REQ-008 min_ones  output  4  minutes digit, BCD.
REQ-009 sec_tens  output  4  seconds tens digit, BCD.
REQ-010 sec_ones  output  4  seconds ones digit, BCD.
REQ-011 digit_count  output  2  digits entered since reset/clear, saturating at 3.
REQ-012 loaded  output  1  one-cycle pulse on the cycle a digit is shifted in.

Function
REQ-013 FSM states: IDLE, DEBOUNCE, HELD; registered state, outputs registered.
REQ-014 IDLE: on valid=1 and enablen=0, latch D into a capture register, load the debounce counter with 1, go to DEBOUNCE.
REQ-015 DEBOUNCE: if valid=0, return to IDLE with no shift; if D differs from the captured code, re-capture D and restart the count at 1.
REQ-016 DEBOUNCE: when the count reaches DEBOUNCE_CYCLES with a stable code, shift the captured digit in and go to HELD; latency from first valid cycle to loaded pulse is DEBOUNCE_CYCLES cycles.
REQ-017 Shift: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=captured code; the old min_ones is discarded.
REQ-018 loaded is asserted for exactly the cycle after the shifting edge; digit_count increments on the same edge, saturating at 3.
REQ-019 HELD: no further shifts; return to IDLE only after valid=0 for one cycle (one digit per key press regardless of hold duration).
REQ-020 Codes D>9 with valid=1 are ignored: the FSM stays in or returns to IDLE.
REQ-021 enablen=1 in any state forces IDLE next cycle; digits and digit_count are held.
REQ-022 clear=1 zeroes all digits and digit_count and forces IDLE; clear has priority over a shift in the same cycle, and loaded stays 0.
REQ-023 A key change inside HELD without an intervening release is not accepted.

Reset
REQ-024 rst=1 asynchronously forces IDLE, min_ones=sec_tens=sec_ones=0, digit_count=0, loaded=0, and clears the capture register and debounce counter.
REQ-025 rst asserted mid-debounce discards the pending digit; after release, a new full debounce period is required.

Configuration
REQ-026 Macro SECONDS_LIMIT_EN: when defined, a shift is rejected if the current sec_ones >5 (it would create seconds tens >5); in that case digits, digit_count and loaded are unchanged, and the FSM still goes to HELD.
REQ-027 Without SECONDS_LIMIT_EN, every accepted digit shifts unconditionally.

Verification
REQ-028 Reset, then press key 3 (D=3, valid=1) for 6 cycles, then release -> loaded pulses once on cycle 4; sec_ones=3; digit_count=1.
REQ-029 Enter 1,2,3,4 as separate presses -> min_ones=2, sec_tens=3, sec_ones=4; digit_count=3.
REQ-030 valid=1 with D=5 for 2 cycles, then D=7 for 4 cycles -> exactly one shift, digit 7, loaded on the 4th cycle of D=7.
REQ-031 enablen=1 while pressing D=9 for 10 cycles -> no loaded pulse; outputs unchanged.
REQ-032 Digits 0:4:5 present; clear=1 in the same cycle a debounced shift would occur -> all digits 0, digit_count=0, loaded=0.
REQ-033 With SECONDS_LIMIT_EN, sec_ones=7, then press 2 -> digits unchanged, no loaded pulse; without the macro -> sec_tens=7, sec_ones=2.

Source files
------------

// File: rtl/timer_digit_loader.sv
// Keypad digit loader for an M:SS timer: debounces a BCD key code and shifts it into three digits.
// Optional macro SECONDS_LIMIT_EN rejects a shift that would push a digit >5 into seconds tens.
module timer_digit_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       valid,
  input  logic       enablen,
  input  logic       clear,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] digit_count,
  output logic       loaded
);

  typedef enum logic [1:0] {StIdle, StDebounce, StHeld} state_e;

  localparam logic [4:0] LpCycles = 5'(DEBOUNCE_CYCLES);

  state_e     r_state;
  logic [3:0] r_cap;
  logic [3:0] r_cnt;

  logic w_code_ok;
  logic w_accept;
  logic w_limit_ok;
  logic w_shift;

  assign w_code_ok = valid && (D <= 4'd9);

`ifdef SECONDS_LIMIT_EN
  assign w_limit_ok = (sec_ones <= 4'd5);
`else
  assign w_limit_ok = 1'b1;
`endif

  // A stable code has been seen for DEBOUNCE_CYCLES consecutive sampled cycles.
  always_comb begin
    w_accept = 1'b0;
    if (!clear && !enablen && w_code_ok) begin
      unique case (r_state)
        StIdle:     w_accept = (LpCycles == 5'd1);
        StDebounce: w_accept = (D == r_cap) && (({1'b0, r_cnt} + 5'd1) >= LpCycles);
        default:    w_accept = 1'b0;
      endcase
    end
  end

  assign w_shift = w_accept && w_limit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cap       <= 4'd0;
      r_cnt       <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      digit_count <= 2'd0;
      loaded      <= 1'b0;
    end else begin
      loaded <= w_shift;
      if (w_shift) begin
        min_ones <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= r_state == StIdle ? D : r_cap;
        if (digit_count != 2'd3) digit_count <= digit_count + 2'd1;
      end

      if (clear) begin
        r_state     <= StIdle;
        min_ones    <= 4'd0;
        sec_tens    <= 4'd0;
        sec_ones    <= 4'd0;
        digit_count <= 2'd0;
      end else if (enablen) begin
        r_state <= StIdle;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_code_ok) begin
              r_cap   <= D;
              r_cnt   <= 4'd1;
              r_state <= w_accept ? StHeld : StDebounce;
            end
          end
          StDebounce: begin
            if (!w_code_ok) begin
              r_state <= StIdle;
            end else if (D != r_cap) begin
              r_cap <= D;
              r_cnt <= 4'd1;
            end else if (w_accept) begin
              r_state <= StHeld;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          StHeld: begin
            if (!valid) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_digit_loader.sv
// Bench for timer_digit_loader: directed scenarios plus random key traffic against a
// press-run reference model (honours SECONDS_LIMIT_EN when defined).
module tb_timer_digit_loader;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       valid;
  logic       enablen;
  logic       clear;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [1:0] digit_count;
  logic       loaded;

  timer_digit_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .D           (D),
    .valid       (valid),
    .enablen     (enablen),
    .clear       (clear),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .loaded      (loaded)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: digits plus the current run of identical valid codes and a "key consumed" flag.
  int m_min, m_tens, m_ones, m_cnt, m_loaded;
  int run_code, run_len;
  bit held;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_min = 0; m_tens = 0; m_ones = 0; m_cnt = 0; m_loaded = 0;
    run_code = 0; run_len = 0; held = 0;
  endtask

  task automatic model_edge(input bit v, input int d, input bit en, input bit clr);
    m_loaded = 0;
    if (clr) begin
      m_min = 0; m_tens = 0; m_ones = 0; m_cnt = 0;
      run_len = 0; held = 0;
    end else if (en) begin
      run_len = 0; held = 0;
    end else if (held) begin
      if (!v) held = 0;
    end else if (!v || d > 9) begin
      run_len = 0;
    end else begin
      if (run_len > 0 && d == run_code) run_len++;
      else begin
        run_code = d;
        run_len  = 1;
      end
      if (run_len == N) begin
        run_len = 0;
        held    = 1;
`ifdef SECONDS_LIMIT_EN
        if (m_ones <= 5) begin
`else
        begin
`endif
          m_min = m_tens; m_tens = m_ones; m_ones = run_code;
          if (m_cnt < 3) m_cnt++;
          m_loaded = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_v, got_v;
    exp_v = (m_min << 11) | (m_tens << 7) | (m_ones << 3) | (m_cnt << 1) | m_loaded;
    got_v = {min_ones, sec_tens, sec_ones, digit_count, loaded};
    chk(tag, got_v, exp_v);
  endtask

  task automatic step(input bit v, input int d, input bit en, input bit clr);
    valid = v; D = 4'(d); enablen = en; clear = clr;
    @(posedge clk);
    model_edge(v, d, en, clr);
    #1;
    check_all("model");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("reset");
    rst = 1'b0;
  endtask

  task automatic press(input int d);
    for (int i = 0; i < N; i++) step(1, d, 0, 0);
    step(0, 0, 0, 0);
  endtask

  int pulses, at;

  initial begin
    valid = 0; D = 0; enablen = 0; clear = 0; rst = 0;
    model_reset();
    #1;
    do_reset();
    chk("rst_min", min_ones, 0);
    chk("rst_tens", sec_tens, 0);
    chk("rst_ones", sec_ones, 0);
    chk("rst_cnt", digit_count, 0);
    chk("rst_loaded", loaded, 0);

    // Key 3 held 6 cycles: single pulse after the 4th sampled edge.
    pulses = 0; at = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, 3, 0, 0);
      if (loaded) begin pulses++; at = i; end
    end
    step(0, 0, 0, 0);
    chk("k3_pulses", pulses, 1);
    chk("k3_edge", at, 4);
    chk("k3_ones", sec_ones, 3);
    chk("k3_cnt", digit_count, 1);

    do_reset();
    press(1); press(2); press(3); press(4);
    chk("seq_min", min_ones, 2);
    chk("seq_tens", sec_tens, 3);
    chk("seq_ones", sec_ones, 4);
    chk("seq_cnt", digit_count, 3);

    // Code change mid-debounce restarts the count.
    do_reset();
    pulses = 0; at = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1, i <= 2 ? 5 : 7, 0, 0);
      if (loaded) begin pulses++; at = i; end
    end
    step(0, 0, 0, 0);
    chk("chg_pulses", pulses, 1);
    chk("chg_edge", at, 6);
    chk("chg_ones", sec_ones, 7);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 9, 1, 0);
      if (loaded) pulses++;
    end
    step(0, 0, 0, 0);
    chk("dis_pulses", pulses, 0);
    chk("dis_ones", sec_ones, 7);
    chk("dis_cnt", digit_count, 1);

    // Clear lands on the edge that would have shifted.
    do_reset();
    press(0); press(4); press(5);
    chk("045", {min_ones, sec_tens, sec_ones}, 12'h045);
    for (int i = 0; i < N - 1; i++) step(1, 6, 0, 0);
    step(1, 6, 0, 1);
    chk("clr_digits", {min_ones, sec_tens, sec_ones}, 0);
    chk("clr_cnt", digit_count, 0);
    chk("clr_loaded", loaded, 0);
    step(0, 0, 0, 0);

    do_reset();
    press(7); press(2);
`ifdef SECONDS_LIMIT_EN
    chk("lim_tens", sec_tens, 0);
    chk("lim_ones", sec_ones, 7);
`else
    chk("lim_tens", sec_tens, 7);
    chk("lim_ones", sec_ones, 2);
`endif

    // Reset mid-debounce: a fresh full period is needed afterwards.
    step(1, 3, 0, 0);
    step(1, 3, 0, 0);
    do_reset();
    pulses = 0; at = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1, 3, 0, 0);
      if (loaded) begin pulses++; at = i; end
    end
    step(0, 0, 0, 0);
    chk("mid_rst_edge", at, 4);
    chk("mid_rst_pulses", pulses, 1);

    do_reset();
    begin
      int d;
      bit v;
      d = 0; v = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0) v = ~v;
        if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 11);
        step(v, d, $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
